ysyx22041405_idu_stage: RTL and testbench

YSYX22041405_IDU_STAGE -- requirements
Module: ysyx22041405_idu_stage

---
 rtl/ysyx22041405_idu_stage.sv | 163 ++++++++++++++++
 tb/tb_ysyx22041405_idu_stage.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx22041405_idu_stage.sv
// Decode stage: RISC-V decode, register file with writeback bypass, per-register
// busy scoreboard for RAW/WAW stalls, and a single registered output packet.
module ysyx22041405_idu_stage #(
   parameter int XLEN = 64,
   parameter int NREG = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_inst,
   output logic            in_ready,
   input  logic            flush,
   input  logic            wb_we,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   output logic [XLEN-1:0] out_pc,
   output logic [XLEN-1:0] out_rs1_data,
   output logic [XLEN-1:0] out_rs2_data,
   output logic [XLEN-1:0] out_imm,
   output logic [4:0]      out_rd,
   output logic            out_rd_we,
   output logic [2:0]      out_fmt,
   output logic            out_illegal,
   input  logic            out_ready
);
   // Handshake: a transfer happens on a rising edge where valid && ready.
   localparam int         AW    = $clog2(NREG);
   localparam logic [5:0] NREG6 = 6'(NREG);
   localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
                          FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5, FMT_X = 3'd7;

   logic [XLEN-1:0] r_regs [NREG];
   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busy_nxt;
   logic            r_out_valid;

   logic [4:0]      w_rs1, w_rs2, w_rd;
   logic [2:0]      w_base_fmt, w_fmt;
   logic            w_rs1_used, w_rs2_used, w_rd_used, w_range_bad, w_illegal, w_rd_we;
   logic [63:0]     w_imm64;
   logic [XLEN-1:0] w_rs1_data, w_rs2_data;
   logic            w_wb_ok, w_hit1, w_hit2, w_hitd, w_hazard, w_accept, w_flush_clr;

   assign w_rs1 = in_inst[19:15];
   assign w_rs2 = in_inst[24:20];
   assign w_rd  = in_inst[11:7];

   always_comb begin
      w_base_fmt = FMT_X;
      case (in_inst[6:0])
         7'b0110111, 7'b0010111:                         w_base_fmt = FMT_U;
         7'b1101111:                                     w_base_fmt = FMT_J;
         7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: w_base_fmt = FMT_I;
         7'b1100011:                                     w_base_fmt = FMT_B;
         7'b0100011:                                     w_base_fmt = FMT_S;
         7'b0110011:                                     w_base_fmt = FMT_R;
         7'b0011011:                                     w_base_fmt = (XLEN == 64) ? FMT_I : FMT_X;
         7'b0111011:                                     w_base_fmt = (XLEN == 64) ? FMT_R : FMT_X;
         default:                                        w_base_fmt = FMT_X;
      endcase
   end

   assign w_rs1_used  = (w_base_fmt == FMT_R) || (w_base_fmt == FMT_I) ||
                        (w_base_fmt == FMT_S) || (w_base_fmt == FMT_B);
   assign w_rs2_used  = (w_base_fmt == FMT_R) || (w_base_fmt == FMT_S) || (w_base_fmt == FMT_B);
   assign w_rd_used   = (w_base_fmt == FMT_R) || (w_base_fmt == FMT_I) ||
                        (w_base_fmt == FMT_U) || (w_base_fmt == FMT_J);
   assign w_range_bad = (w_rs1_used && ({1'b0, w_rs1} >= NREG6)) ||
                        (w_rs2_used && ({1'b0, w_rs2} >= NREG6)) ||
                        (w_rd_used  && ({1'b0, w_rd}  >= NREG6));
   assign w_illegal   = (w_base_fmt == FMT_X) || w_range_bad;
   assign w_fmt       = w_illegal ? FMT_X : w_base_fmt;
   assign w_rd_we     = !w_illegal && w_rd_used && (w_rd != 5'd0);

   always_comb begin
      w_imm64 = 64'd0;
      case (w_fmt)
         FMT_I:   w_imm64 = {{52{in_inst[31]}}, in_inst[31:20]};
         FMT_S:   w_imm64 = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
         FMT_B:   w_imm64 = {{51{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                             in_inst[11:8], 1'b0};
         FMT_U:   w_imm64 = {{32{in_inst[31]}}, in_inst[31:12], 12'd0};
         FMT_J:   w_imm64 = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                             in_inst[30:21], 1'b0};
         default: w_imm64 = 64'd0;
      endcase
   end

   assign w_wb_ok = wb_we && ({1'b0, wb_addr} < NREG6);
   assign w_hit1  = wb_we && (wb_addr == w_rs1);
   assign w_hit2  = wb_we && (wb_addr == w_rs2);
   assign w_hitd  = wb_we && (wb_addr == w_rd);

   // Register reads see a same-cycle writeback so a stalled consumer can leave on the wb edge.
   always_comb begin
      w_rs1_data = '0;
      w_rs2_data = '0;
      if ((w_rs1 != 5'd0) && ({1'b0, w_rs1} < NREG6))
         w_rs1_data = w_hit1 ? wb_data : r_regs[w_rs1[AW-1:0]];
      if ((w_rs2 != 5'd0) && ({1'b0, w_rs2} < NREG6))
         w_rs2_data = w_hit2 ? wb_data : r_regs[w_rs2[AW-1:0]];
   end

   assign w_hazard = in_valid && !w_illegal &&
                     ((w_rs1_used && r_busy[w_rs1[AW-1:0]] && !w_hit1) ||
                      (w_rs2_used && r_busy[w_rs2[AW-1:0]] && !w_hit2) ||
                      (w_rd_we    && r_busy[w_rd[AW-1:0]]  && !w_hitd));
   assign in_ready    = (!r_out_valid || out_ready) && !w_hazard && !flush && !rst;
   assign w_accept    = in_valid && in_ready;
   assign w_flush_clr = flush && r_out_valid && out_rd_we && !out_ready;

   // Clears first, then the set, so a same-cycle set of the same register wins.
   always_comb begin
      w_busy_nxt = r_busy;
      if (w_wb_ok)     w_busy_nxt[wb_addr[AW-1:0]] = 1'b0;
      if (w_flush_clr) w_busy_nxt[out_rd[AW-1:0]]  = 1'b0;
      if (w_accept && w_rd_we) w_busy_nxt[w_rd[AW-1:0]] = 1'b1;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_busy <= '0;
         for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
      end else begin
         r_busy <= w_busy_nxt;
         if (w_wb_ok && (wb_addr != 5'd0)) r_regs[wb_addr[AW-1:0]] <= wb_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         out_pc       <= '0;
         out_rs1_data <= '0;
         out_rs2_data <= '0;
         out_imm      <= '0;
         out_rd       <= '0;
         out_rd_we    <= 1'b0;
         out_fmt      <= '0;
         out_illegal  <= 1'b0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_out_valid  <= 1'b1;
         out_pc       <= in_pc;
         out_rs1_data <= w_rs1_data;
         out_rs2_data <= w_rs2_data;
         out_imm      <= w_imm64[XLEN-1:0];
         out_rd       <= w_rd;
         out_rd_we    <= w_rd_we;
         out_fmt      <= w_fmt;
         out_illegal  <= w_illegal;
      end else if (out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;

endmodule

// File: tb/tb_ysyx22041405_idu_stage.sv
// Bench for the decode stage: directed scenarios plus randomized traffic on a 64-bit
// RV-I instance, with directed decode checks on RV-E and 32-bit instances.
module tb_ysyx22041405_idu_stage;
   typedef struct packed {
      logic [2:0]  fmt;
      logic        ill;
      logic [63:0] imm;
      logic        rs1u;
      logic        rs2u;
      logic        rdwe;
   } dec_t;

   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] rs1;
      logic [63:0] rs2;
      logic [63:0] imm;
      logic [4:0]  rd;
      logic        rd_we;
      logic [2:0]  fmt;
      logic        ill;
      logic        rs1u;
      logic        rs2u;
   } pkt_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        in_valid, in_ready, flush, wb_we, out_ready;
   logic [63:0] in_pc, wb_data;
   logic [31:0] in_inst;
   logic [4:0]  wb_addr;
   logic        out_valid, out_rd_we, out_illegal;
   logic [63:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
   logic [4:0]  out_rd;
   logic [2:0]  out_fmt;

   logic        e_in_valid, e_in_ready, e_out_valid, e_out_rd_we, e_out_illegal;
   logic [31:0] e_in_inst;
   logic [63:0] e_out_pc, e_out_rs1_data, e_out_rs2_data, e_out_imm;
   logic [4:0]  e_out_rd;
   logic [2:0]  e_out_fmt;

   logic        x_in_valid, x_in_ready, x_out_valid, x_out_rd_we, x_out_illegal;
   logic [31:0] x_in_inst;
   logic [31:0] x_out_pc, x_out_rs1_data, x_out_rs2_data, x_out_imm;
   logic [4:0]  x_out_rd;
   logic [2:0]  x_out_fmt;

   ysyx22041405_idu_stage #(.XLEN(64), .NREG(32)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_inst(in_inst),
      .in_ready(in_ready), .flush(flush), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
      .out_valid(out_valid), .out_pc(out_pc), .out_rs1_data(out_rs1_data),
      .out_rs2_data(out_rs2_data), .out_imm(out_imm), .out_rd(out_rd), .out_rd_we(out_rd_we),
      .out_fmt(out_fmt), .out_illegal(out_illegal), .out_ready(out_ready));

   ysyx22041405_idu_stage #(.XLEN(64), .NREG(16)) dut_e16 (
      .clk(clk), .rst(rst), .in_valid(e_in_valid), .in_pc(64'h40), .in_inst(e_in_inst),
      .in_ready(e_in_ready), .flush(1'b0), .wb_we(1'b0), .wb_addr(5'd0), .wb_data(64'd0),
      .out_valid(e_out_valid), .out_pc(e_out_pc), .out_rs1_data(e_out_rs1_data),
      .out_rs2_data(e_out_rs2_data), .out_imm(e_out_imm), .out_rd(e_out_rd),
      .out_rd_we(e_out_rd_we), .out_fmt(e_out_fmt), .out_illegal(e_out_illegal),
      .out_ready(1'b1));

   ysyx22041405_idu_stage #(.XLEN(32), .NREG(32)) dut_x32 (
      .clk(clk), .rst(rst), .in_valid(x_in_valid), .in_pc(32'h80), .in_inst(x_in_inst),
      .in_ready(x_in_ready), .flush(1'b0), .wb_we(1'b0), .wb_addr(5'd0), .wb_data(32'd0),
      .out_valid(x_out_valid), .out_pc(x_out_pc), .out_rs1_data(x_out_rs1_data),
      .out_rs2_data(x_out_rs2_data), .out_imm(x_out_imm), .out_rd(x_out_rd),
      .out_rd_we(x_out_rd_we), .out_fmt(x_out_fmt), .out_illegal(x_out_illegal),
      .out_ready(1'b1));

   int          n_checks = 0;
   int          n_errors = 0;
   pkt_t        exp_q[$];
   logic [63:0] m_regs [32];
   logic        m_busy [32];
   logic        m_valid = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference decode from the RV opcode map; immediates built with signed arithmetic.
   function automatic dec_t ref_decode(input logic [31:0] x, input int xlen, input int nreg);
      dec_t   d;
      int     f;
      longint sx, v;
      logic   rdu;
      sx = longint'($signed(x));
      f  = -1;
      if (x[1:0] == 2'b11) begin
         case (x[6:2])
            5'b01101, 5'b00101:                   f = 4;
            5'b11011:                             f = 5;
            5'b11001, 5'b00000, 5'b00100, 5'b11100: f = 1;
            5'b11000:                             f = 3;
            5'b01000:                             f = 2;
            5'b01100:                             f = 0;
            5'b00110:                             f = (xlen == 64) ? 1 : -1;
            5'b01110:                             f = (xlen == 64) ? 0 : -1;
            default:                              f = -1;
         endcase
      end
      d.rs1u = (f == 0 || f == 1 || f == 2 || f == 3);
      d.rs2u = (f == 0 || f == 2 || f == 3);
      rdu    = (f == 0 || f == 1 || f == 4 || f == 5);
      if (f >= 0 && nreg == 16 && ((d.rs1u && x[19]) || (d.rs2u && x[24]) || (rdu && x[11]))) f = -1;
      d.ill = (f < 0);
      case (f)
         1:       v = sx >>> 20;
         2:       v = ((sx >>> 25) <<< 5) | longint'(x[11:7]);
         3:       v = ((sx >>> 31) <<< 12) | (longint'(x[7]) << 11) | (longint'(x[30:25]) << 5) |
                      (longint'(x[11:8]) << 1);
         4:       v = sx & ~longint'(64'hFFF);
         5:       v = ((sx >>> 31) <<< 20) | (longint'(x[19:12]) << 12) | (longint'(x[20]) << 11) |
                      (longint'(x[30:21]) << 1);
         default: v = 0;
      endcase
      d.imm  = (xlen == 32) ? {32'd0, v[31:0]} : v;
      d.fmt  = d.ill ? 3'd7 : f[2:0];
      d.rdwe = !d.ill && rdu && (x[11:7] != 5'd0);
      if (d.ill) begin
         d.rs1u = 1'b0;
         d.rs2u = 1'b0;
      end
      return d;
   endfunction

   function automatic logic [63:0] model_read(input logic [4:0] r);
      if (r == 5'd0) return 64'd0;
      if (wb_we && wb_addr == r) return wb_data;
      return m_regs[r];
   endfunction

   function automatic logic model_busy(input logic [4:0] r);
      return m_busy[r] && !(wb_we && wb_addr == r);
   endfunction

   // Reference model: runs after the monitor each cycle, predicts in_ready and accepted packets.
   always @(negedge clk) begin : model
      dec_t d;
      pkt_t p;
      logic haz, exp_ready, hs, acc;
      #1;
      if (rst) begin
         check("reset in_ready", {63'd0, in_ready}, 64'd0);
         exp_q.delete();
         m_valid = 1'b0;
         for (int i = 0; i < 32; i++) begin
            m_busy[i] = 1'b0;
            m_regs[i] = 64'd0;
         end
      end else begin
         d   = ref_decode(in_inst, 64, 32);
         haz = in_valid && !d.ill && ((d.rs1u && model_busy(in_inst[19:15])) ||
                                      (d.rs2u && model_busy(in_inst[24:20])) ||
                                      (d.rdwe && model_busy(in_inst[11:7])));
         exp_ready = (!m_valid || out_ready) && !haz && !flush;
         check("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
         hs  = m_valid && out_ready;
         acc = in_valid && exp_ready;
         if (flush && m_valid && !hs && exp_q.size() != 0) begin
            p = exp_q.pop_front();
            if (p.rd_we) m_busy[p.rd] = 1'b0;
         end
         if (wb_we) m_busy[wb_addr] = 1'b0;
         if (acc) begin
            p.pc    = in_pc;
            p.rs1   = model_read(in_inst[19:15]);
            p.rs2   = model_read(in_inst[24:20]);
            p.imm   = d.imm;
            p.rd    = in_inst[11:7];
            p.rd_we = d.rdwe;
            p.fmt   = d.fmt;
            p.ill   = d.ill;
            p.rs1u  = d.rs1u;
            p.rs2u  = d.rs2u;
            exp_q.push_back(p);
            if (d.rdwe) m_busy[in_inst[11:7]] = 1'b1;
         end
         if (wb_we && wb_addr != 5'd0) m_regs[wb_addr] = wb_data;
         m_busy[0] = 1'b0;
         m_valid = flush ? 1'b0 : acc ? 1'b1 : hs ? 1'b0 : m_valid;
      end
   end

   // Monitor: compares the presented packet with the queue head every cycle, pops on handshake.
   always @(negedge clk) begin : monitor
      pkt_t p;
      if (!rst) begin
         check("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() != 0});
         if (out_valid && exp_q.size() != 0) begin
            p = exp_q[0];
            check("out_pc", out_pc, p.pc);
            check("out_imm", out_imm, p.imm);
            check("out_fmt", {61'd0, out_fmt}, {61'd0, p.fmt});
            check("out_illegal", {63'd0, out_illegal}, {63'd0, p.ill});
            check("out_rd_we", {63'd0, out_rd_we}, {63'd0, p.rd_we});
            if (p.rd_we) check("out_rd", {59'd0, out_rd}, {59'd0, p.rd});
            if (p.rs1u)  check("out_rs1_data", out_rs1_data, p.rs1);
            if (p.rs2u)  check("out_rs2_data", out_rs2_data, p.rs2);
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      in_inst   = 32'h00000013;
      in_pc     = 64'h0;
      flush     = 1'b0;
      wb_we     = 1'b0;
      wb_addr   = 5'd0;
      wb_data   = 64'd0;
      out_ready = 1'b1;
   endtask

   task automatic wb_only(input logic [4:0] a);
      step();
      idle();
      wb_we   = 1'b1;
      wb_addr = a;
      wb_data = {$urandom, $urandom};
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] x;
      int          k;
      x = $urandom;
      k = $urandom_range(0, 13);
      x[19:15] = 5'($urandom_range(0, 7));
      x[24:20] = 5'($urandom_range(0, 7));
      x[11:7]  = 5'($urandom_range(0, 7));
      case (k)
         0:  x[6:0] = 7'b0110111;
         1:  x[6:0] = 7'b0010111;
         2:  x[6:0] = 7'b1101111;
         3:  x[6:0] = 7'b1100111;
         4:  x[6:0] = 7'b0000011;
         5:  x[6:0] = 7'b0010011;
         6:  x[6:0] = 7'b1110011;
         7:  x[6:0] = 7'b1100011;
         8:  x[6:0] = 7'b0100011;
         9:  x[6:0] = 7'b0110011;
         10: x[6:0] = 7'b0011011;
         11: x[6:0] = 7'b0111011;
         12: x[1:0] = 2'b01;
         default: ;
      endcase
      return x;
   endfunction

   function automatic logic [4:0] pick_wb();
      logic [4:0] busy_list[$];
      for (int i = 1; i < 32; i++) if (m_busy[i]) busy_list.push_back(5'(i));
      if (busy_list.size() != 0 && $urandom_range(0, 99) < 70)
         return busy_list[$urandom_range(0, busy_list.size() - 1)];
      return 5'($urandom_range(0, 31));
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      idle();
      e_in_valid = 1'b0;
      e_in_inst  = 32'h13;
      x_in_valid = 1'b0;
      x_in_inst  = 32'h13;
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         check("rst out_valid", {63'd0, out_valid}, 64'd0);
         check("rst out_imm", out_imm, 64'd0);
         check("rst out_pc", out_pc, 64'd0);
         check("rst out_rd", {59'd0, out_rd}, 64'd0);
         check("rst out_fmt", {61'd0, out_fmt}, 64'd0);
      end

      // Writeback then dependent ADDI.
      step(); rst = 1'b0; wb_we = 1'b1; wb_addr = 5'd5; wb_data = 64'h1234;
      step(); idle(); in_valid = 1'b1; in_inst = 32'hFFF28313; in_pc = 64'h8000_0000;
      @(negedge clk); check("addi in_ready", {63'd0, in_ready}, 64'd1);
      step(); idle(); wb_we = 1'b1; wb_addr = 5'd6; wb_data = 64'h66;
      @(negedge clk);
      check("addi out_valid", {63'd0, out_valid}, 64'd1);
      check("addi rs1", out_rs1_data, 64'h1234);
      check("addi imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      check("addi rd", {59'd0, out_rd}, 64'd6);
      check("addi fmt", {61'd0, out_fmt}, 64'd1);

      // Load-use stall released by writeback of x7.
      step(); idle(); in_valid = 1'b1; in_inst = 32'h0000A383;
      @(negedge clk); check("lw in_ready", {63'd0, in_ready}, 64'd1);
      step(); idle(); in_valid = 1'b1; in_inst = 32'h00738433;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); check("add stall", {63'd0, in_ready}, 64'd0);
         step();
      end
      wb_we = 1'b1; wb_addr = 5'd7; wb_data = 64'hABCD;
      @(negedge clk); check("add accept on wb", {63'd0, in_ready}, 64'd1);
      step(); idle(); wb_we = 1'b1; wb_addr = 5'd8; wb_data = 64'h88;
      @(negedge clk);
      check("add rs1 bypass", out_rs1_data, 64'hABCD);
      check("add rs2 bypass", out_rs2_data, 64'hABCD);
      check("add rd", {59'd0, out_rd}, 64'd8);

      // Output backpressure then back-to-back flow.
      step(); idle(); in_valid = 1'b1; in_inst = 32'h00500593;
      @(negedge clk); check("x11 in_ready", {63'd0, in_ready}, 64'd1);
      step(); idle(); out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h00600613;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold out_valid", {63'd0, out_valid}, 64'd1);
         check("hold out_rd", {59'd0, out_rd}, 64'd11);
         check("hold out_imm", out_imm, 64'd5);
         check("hold in_ready", {63'd0, in_ready}, 64'd0);
         step();
      end
      out_ready = 1'b1;
      @(negedge clk); check("b2b accept x12", {63'd0, in_ready}, 64'd1);
      step(); in_inst = 32'h00700693;
      @(negedge clk);
      check("b2b accept x13", {63'd0, in_ready}, 64'd1);
      check("b2b out_rd x12", {59'd0, out_rd}, 64'd12);
      step(); idle();
      @(negedge clk);
      check("b2b out_valid x13", {63'd0, out_valid}, 64'd1);
      check("b2b out_rd x13", {59'd0, out_rd}, 64'd13);
      wb_only(5'd11); wb_only(5'd12); wb_only(5'd13);

      // Flush of a registered packet writing x9 releases its busy bit.
      step(); idle(); in_valid = 1'b1; in_inst = 32'h00100493; out_ready = 1'b0;
      @(negedge clk); check("x9 in_ready", {63'd0, in_ready}, 64'd1);
      step(); idle(); out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00048713;
      @(negedge clk); check("flush blocks accept", {63'd0, in_ready}, 64'd0);
      step(); idle(); in_valid = 1'b1; in_inst = 32'h00048713;
      @(negedge clk);
      check("flush out_valid", {63'd0, out_valid}, 64'd0);
      check("read x9 no stall", {63'd0, in_ready}, 64'd1);
      step(); idle();
      @(negedge clk); check("x14 out_rd", {59'd0, out_rd}, 64'd14);

      // LUI sign extension on 64-bit; RV-E index range; OP-32 on 32-bit.
      step(); idle(); in_valid = 1'b1; in_inst = 32'h80000537; wb_we = 1'b1; wb_addr = 5'd14;
      e_in_valid = 1'b1; e_in_inst = 32'h00208A33;
      x_in_valid = 1'b1; x_in_inst = 32'h002080BB;
      @(negedge clk);
      check("e16 illegal no stall", {63'd0, e_in_ready}, 64'd1);
      check("x32 illegal no stall", {63'd0, x_in_ready}, 64'd1);
      step(); idle(); e_in_inst = 32'h00020293; x_in_inst = 32'h80000537;
      @(negedge clk);
      check("lui64 imm", out_imm, 64'hFFFF_FFFF_8000_0000);
      check("lui64 fmt", {61'd0, out_fmt}, 64'd4);
      check("e16 illegal", {63'd0, e_out_illegal}, 64'd1);
      check("e16 fmt", {61'd0, e_out_fmt}, 64'd7);
      check("e16 rd_we", {63'd0, e_out_rd_we}, 64'd0);
      check("e16 no busy set", {63'd0, e_in_ready}, 64'd1);
      check("x32 illegal", {63'd0, x_out_illegal}, 64'd1);
      check("x32 fmt", {61'd0, x_out_fmt}, 64'd7);
      check("x32 rd_we", {63'd0, x_out_rd_we}, 64'd0);
      step(); idle(); e_in_valid = 1'b0; x_in_valid = 1'b0; wb_we = 1'b1; wb_addr = 5'd10;
      @(negedge clk);
      check("e16 addi legal", {63'd0, e_out_illegal}, 64'd0);
      check("x32 lui imm", {32'd0, x_out_imm}, 64'h8000_0000);

      // Reset during a pending handshake discards the packet.
      step(); idle(); in_valid = 1'b1; in_inst = 32'h00100793; out_ready = 1'b0;
      @(negedge clk); check("x15 in_ready", {63'd0, in_ready}, 64'd1);
      step(); rst = 1'b1;
      @(negedge clk); check("rst mid in_ready", {63'd0, in_ready}, 64'd0);
      step();
      @(negedge clk); check("rst mid out_valid", {63'd0, out_valid}, 64'd0);
      step(); rst = 1'b0; out_ready = 1'b1;
      @(negedge clk); check("post-rst accept", {63'd0, in_ready}, 64'd1);
      step(); idle();

      // Randomized traffic against the reference model.
      for (int c = 0; c < 3000; c++) begin
         step();
         in_valid  = ($urandom_range(0, 99) < 70);
         in_inst   = rand_inst();
         in_pc     = {$urandom, $urandom};
         out_ready = ($urandom_range(0, 99) < 70);
         flush     = ($urandom_range(0, 99) < 5);
         wb_we     = ($urandom_range(0, 99) < 40);
         wb_addr   = pick_wb();
         wb_data   = {$urandom, $urandom};
      end
      step(); idle();
      repeat (4) step();
      @(negedge clk);
      check("drain", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
